radar_pulse_capture: RTL and testbench
======================================

Name: radar_pulse_capture

Overview:
- Sits directly downstream of the ADC interface stage, in the ADC clock domain.
- Channel B (trigger, two's complement) feeds a Schmitt trigger detector with holdoff.
- Each accepted trigger starts a capture of a decimated window of channel A samples (video, linear, never 0), emitted as a valid-qualified stream with first/last markers for the buffer writer.

Parameters:
- DW, 14, ADC sample width.
- CW, 32, width of delay, holdoff and trigger counters.
- NW, 16, width of sample-count and decimation fields.

Ports:
- adc_clk_i  in  1  ADC clock; the only clock.
- adc_rst_i  in  1  asynchronous, active-low reset.
- adc_dat_a_i  in  DW  video sample, unsigned linear, never 0.
- adc_dat_b_i  in  DW  trigger sample, signed two's complement.
- enable_i  in  1  capture/detect enable.
- trig_excite_i  in  DW  signed; trigger fires when B >= this.
- trig_relax_i  in  DW  signed; detector rearms when B <= this.
- trig_holdoff_i  in  CW  samples after a trigger during which no trigger may fire.
- trig_delay_i  in  CW  samples from trigger to first capture.
- n_samples_i  in  NW  samples per capture.
- decim_i  in  NW  decimation rate; 0 is treated as 1.
- vid_dat_o  out  DW  captured video sample.
- vid_valid_o  out  1  vid_dat_o valid this cycle.
- vid_first_o  out  1  first sample of a capture.
- vid_last_o  out  1  last sample of a capture.
- trig_o  out  1  one-cycle trigger pulse.
- trig_count_o  out  CW  triggers detected since reset.
- missed_count_o  out  CW  triggers ignored because a capture was busy.
- busy_o  out  1  state is DELAY or CAPTURE.

Behaviour:
- Reset: all outputs 0, state IDLE, detector armed, holdoff counter 0.
- Detector (runs only while enable_i = 1):
  - Fires on the sample of cycle k when: armed, holdoff counter = 0, and signed B >= trig_excite_i.
  - On fire: disarm, load holdoff counter with trig_holdoff_i, assert trig_o on cycle k+1, increment trig_count_o (wraps).
  - Rearm when signed B <= trig_relax_i. Rearm is independent of holdoff.
  - If excite <= relax, fire takes precedence on a sample satisfying both.
- FSM states: IDLE, WAIT_TRIG, DELAY, CAPTURE.
  - IDLE: enable_i=1 -> WAIT_TRIG.
  - WAIT_TRIG, on a fire: latch trig_delay_i, n_samples_i, decim_i.
    - n_samples_i=0 -> stay in WAIT_TRIG, no output.
    - trig_delay_i=0 -> CAPTURE.
    - otherwise -> DELAY.
  - DELAY: count D latched samples, then -> CAPTURE.
  - CAPTURE: capture samples k+1+D+j*M for j = 0..N-1 (M = max(decim,1)).
    - Each captured sample appears on vid_dat_o with vid_valid_o one cycle after its input cycle.
    - Sample j=0 carries vid_first_o; sample j=N-1 carries vid_last_o. With N=1 both are set.
    - After the last sample -> WAIT_TRIG in the same cycle the last sample is accepted.
- Latency: trigger on sample k -> first output on cycle k+2+D.
- A fire outside WAIT_TRIG (DELAY/CAPTURE) increments missed_count_o (wraps) and is otherwise ignored. trig_o and trig_count_o still update.
- A fire on the cycle the last sample is accepted counts as missed.
- enable_i deassert in any state:
  - Next cycle -> IDLE.
  - Any pending output already registered completes; no further valid.
  - vid_last_o is not generated for the aborted capture.
  - Detector holdoff freezes; armed state is kept.
- Config inputs change only at trigger latch; mid-capture changes have no effect.
- Reset mid-capture: immediate abort, all outputs 0.
- vid_dat_o is held at its last value when not valid.

Decomposition:
- Shared package: DW, CW, NW widths and the FSM state encoding constants.
- One sub-module: schmitt_trigger, covering threshold compare, arm state, holdoff counter and fire pulse.
- FSM, delay/decimation counters and output register live in the top.

Test Plan:
- Ramp B from -8000 to +8000 in steps of 1000, excite=2000, relax=-2000, holdoff=0 -> exactly one trig_o, on the cycle after B reaches 2000; no second fire until B <= -2000 and rises again.
- Delay=5, N=4, decim=1, A = incrementing counter, trigger on sample 100 -> vid_valid_o on cycles 107-110 with data of samples 106-109; first on 107, last on 110.
- Decim=3, N=3, delay=0, trigger on sample 50 -> samples 51, 54, 57 output on cycles 52, 55, 58.
- Holdoff=20: B toggles between 3000 and -3000 every 5 samples -> fires spaced at least 21 samples apart; trig_count_o matches the count of fires.
- N=1000 capture with a second valid fire at j=10 -> missed_count_o=1, trig_count_o=2, capture unaffected; a fire on the cycle after vid_last_o starts a new capture.
- enable_i low at j=2 of N=8 -> no vid_last_o, no valid from 2 cycles later; re-enable -> next trigger captures normally. Async reset mid-DELAY -> all outputs 0 immediately.

Source files
------------

// File: rtl/radar_pulse_capture_pkg.sv
// Shared definitions for the radar pulse capture block.
// Contents:
//   DEF_DW / DEF_CW / DEF_NW - default widths for ADC samples,
//                              32-bit counters and sample-count/decimation fields.
//   cap_state_t              - capture FSM state encoding, also exported on
//                              the debug state port of the top.
package radar_pulse_capture_pkg;

    localparam int DEF_DW = 14;
    localparam int DEF_CW = 32;
    localparam int DEF_NW = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_DELAY     = 2'd2,
        ST_CAPTURE   = 2'd3
    } cap_state_t;

endpackage

// File: rtl/radar_pulse_capture_schmitt_trigger.sv
// Schmitt trigger detector with holdoff for the radar trigger channel.
// Ports:
//   clk, rst_n   - ADC clock, asynchronous active-low reset
//   enable       - detector runs only while high; otherwise arm state and
//                  holdoff counter are frozen
//   dat          - trigger sample, signed two's complement
//   excite       - signed fire threshold (fires when dat >= excite)
//   relax        - signed rearm threshold (rearms when dat <= relax)
//   holdoff      - samples after a fire during which no fire may occur
//   fire         - combinational: the current sample fires (one cycle)
//   trig         - registered copy of fire, one cycle after the sample
//   trig_count   - wrapping count of fires since reset
module radar_pulse_capture_schmitt_trigger
    import radar_pulse_capture_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [DW-1:0] dat,
    input  logic [DW-1:0] excite,
    input  logic [DW-1:0] relax,
    input  logic [CW-1:0] holdoff,
    output logic          fire,
    output logic          trig,
    output logic [CW-1:0] trig_count
);

    logic          armed;
    logic [CW-1:0] holdoff_cnt;
    logic          above;
    logic          below;

    assign above = $signed(dat) >= $signed(excite);
    assign below = $signed(dat) <= $signed(relax);
    assign fire  = enable && armed && (holdoff_cnt == '0) && above;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed       <= 1'b1;
            holdoff_cnt <= '0;
            trig        <= 1'b0;
            trig_count  <= '0;
        end else begin
            trig <= fire;
            if (fire) begin
                // Fire wins over rearm when one sample satisfies both thresholds.
                armed       <= 1'b0;
                holdoff_cnt <= holdoff;
                trig_count  <= trig_count + CW'(1);
            end else if (enable) begin
                // Rearm does not wait for holdoff to expire.
                if (below) begin
                    armed <= 1'b1;
                end
                if (holdoff_cnt != '0) begin
                    holdoff_cnt <= holdoff_cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/radar_pulse_capture.sv
// Triggered, decimated capture of the radar video channel.
// Channel B drives a Schmitt trigger; each accepted fire captures N samples
// of channel A, one every M samples, starting D samples after the fire.
// Output stream: valid-only, no backpressure. vid_dat_o is meaningful only
// while vid_valid_o is high; vid_first_o / vid_last_o are only ever high
// together with vid_valid_o. vid_dat_o holds its last value otherwise.
// Ports:
//   adc_clk_i, adc_rst_i   - clock, asynchronous active-low reset
//   adc_dat_a_i            - video sample (unsigned, never 0)
//   adc_dat_b_i            - trigger sample (signed)
//   enable_i               - capture/detect enable
//   trig_excite_i/relax_i  - signed Schmitt thresholds
//   trig_holdoff_i         - holdoff after a fire, in samples
//   trig_delay_i           - samples from fire to first capture
//   n_samples_i / decim_i  - samples per capture / decimation (0 acts as 1)
//   vid_*_o                - captured stream with first/last markers
//   trig_o, trig_count_o   - trigger pulse and wrapping fire count
//   missed_count_o         - fires ignored because a capture was in progress
//   busy_o                 - FSM in DELAY or CAPTURE
//   state_o                - debug view of the FSM state
module radar_pulse_capture
    import radar_pulse_capture_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int CW = DEF_CW,
    parameter int NW = DEF_NW
) (
    input  logic          adc_clk_i,
    input  logic          adc_rst_i,
    input  logic [DW-1:0] adc_dat_a_i,
    input  logic [DW-1:0] adc_dat_b_i,
    input  logic          enable_i,
    input  logic [DW-1:0] trig_excite_i,
    input  logic [DW-1:0] trig_relax_i,
    input  logic [CW-1:0] trig_holdoff_i,
    input  logic [CW-1:0] trig_delay_i,
    input  logic [NW-1:0] n_samples_i,
    input  logic [NW-1:0] decim_i,
    output logic [DW-1:0] vid_dat_o,
    output logic          vid_valid_o,
    output logic          vid_first_o,
    output logic          vid_last_o,
    output logic          trig_o,
    output logic [CW-1:0] trig_count_o,
    output logic [CW-1:0] missed_count_o,
    output logic          busy_o,
    output logic [1:0]    state_o
);

    cap_state_t    state;
    logic          fire;
    logic [CW-1:0] delay_cnt;
    logic [NW-1:0] decim_rate;
    logic [NW-1:0] decim_cnt;
    logic [NW-1:0] remain;
    logic          first_pend;

    radar_pulse_capture_schmitt_trigger #(
        .DW (DW),
        .CW (CW)
    ) u_schmitt_trigger (
        .clk        (adc_clk_i),
        .rst_n      (adc_rst_i),
        .enable     (enable_i),
        .dat        (adc_dat_b_i),
        .excite     (trig_excite_i),
        .relax      (trig_relax_i),
        .holdoff    (trig_holdoff_i),
        .fire       (fire),
        .trig       (trig_o),
        .trig_count (trig_count_o)
    );

    assign busy_o  = (state == ST_DELAY) || (state == ST_CAPTURE);
    assign state_o = state;

    always_ff @(posedge adc_clk_i or negedge adc_rst_i) begin
        if (!adc_rst_i) begin
            state          <= ST_IDLE;
            delay_cnt      <= '0;
            decim_rate     <= '0;
            decim_cnt      <= '0;
            remain         <= '0;
            first_pend     <= 1'b0;
            vid_dat_o      <= '0;
            vid_valid_o    <= 1'b0;
            vid_first_o    <= 1'b0;
            vid_last_o     <= 1'b0;
            missed_count_o <= '0;
        end else begin
            vid_valid_o <= 1'b0;
            vid_first_o <= 1'b0;
            vid_last_o  <= 1'b0;

            // The cycle accepting the last sample is still CAPTURE, so a fire
            // there is counted as missed.
            if (fire && ((state == ST_DELAY) || (state == ST_CAPTURE))) begin
                missed_count_o <= missed_count_o + CW'(1);
            end

            if (!enable_i) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_WAIT_TRIG;
                    end
                    ST_WAIT_TRIG: begin
                        if (fire && (n_samples_i != '0)) begin
                            delay_cnt  <= trig_delay_i;
                            decim_rate <= (decim_i == '0) ? NW'(1) : decim_i;
                            decim_cnt  <= '0;
                            remain     <= n_samples_i;
                            first_pend <= 1'b1;
                            state      <= (trig_delay_i == '0) ? ST_CAPTURE : ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        // Leaving on a count of 1 makes the first capture land
                        // exactly D samples after the fire sample + 1.
                        if (delay_cnt == CW'(1)) begin
                            state <= ST_CAPTURE;
                        end else begin
                            delay_cnt <= delay_cnt - CW'(1);
                        end
                    end
                    ST_CAPTURE: begin
                        if (decim_cnt == '0) begin
                            vid_dat_o   <= adc_dat_a_i;
                            vid_valid_o <= 1'b1;
                            vid_first_o <= first_pend;
                            vid_last_o  <= (remain == NW'(1));
                            first_pend  <= 1'b0;
                            remain      <= remain - NW'(1);
                            decim_cnt   <= decim_rate - NW'(1);
                            if (remain == NW'(1)) begin
                                state <= ST_WAIT_TRIG;
                            end
                        end else begin
                            decim_cnt <= decim_cnt - NW'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_radar_pulse_capture.sv
// Directed bench for radar_pulse_capture. The video input carries the index
// of the clock edge that samples it, so captured data identifies the sample.
module tb_radar_pulse_capture;

    localparam int DW = 14;
    localparam int CW = 32;
    localparam int NW = 16;

    localparam logic [31:0] S_IDLE    = 32'd0;
    localparam logic [31:0] S_WAIT    = 32'd1;
    localparam logic [31:0] S_DELAY   = 32'd2;
    localparam logic [31:0] S_CAPTURE = 32'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          enable;
    logic [DW-1:0] excite;
    logic [DW-1:0] relax;
    logic [CW-1:0] holdoff;
    logic [CW-1:0] delay;
    logic [NW-1:0] n_samples;
    logic [NW-1:0] decim;
    logic [DW-1:0] vid_dat;
    logic          vid_valid;
    logic          vid_first;
    logic          vid_last;
    logic          trig;
    logic [CW-1:0] trig_count;
    logic [CW-1:0] missed_count;
    logic          busy;
    logic [1:0]    state;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int exp_trig = 0;
    int trig_seen = 0;
    int valid_seen = 0;
    int trig_edge = -1;

    logic [31:0] exp_q[$];

    // clock / reset block
    always #5 clk = ~clk;

    radar_pulse_capture #(
        .DW (DW),
        .CW (CW),
        .NW (NW)
    ) dut (
        .adc_clk_i      (clk),
        .adc_rst_i      (rst_n),
        .adc_dat_a_i    (a),
        .adc_dat_b_i    (b),
        .enable_i       (enable),
        .trig_excite_i  (excite),
        .trig_relax_i   (relax),
        .trig_holdoff_i (holdoff),
        .trig_delay_i   (delay),
        .n_samples_i    (n_samples),
        .decim_i        (decim),
        .vid_dat_o      (vid_dat),
        .vid_valid_o    (vid_valid),
        .vid_first_o    (vid_first),
        .vid_last_o     (vid_last),
        .trig_o         (trig),
        .trig_count_o   (trig_count),
        .missed_count_o (missed_count),
        .busy_o         (busy),
        .state_o        (state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // Advance one clock edge; outputs are sampled 1 time unit after it and the
    // next video sample (value = index of the edge that will sample it) is set.
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
        a = DW'(edge_n + 1);
    endtask

    task automatic set_b(input int v);
        b = v[DW-1:0];
    endtask

    task automatic drive_b(input int v);
        set_b(v);
        tick();
        if (trig) begin
            trig_seen++;
            trig_edge = edge_n;
        end
        if (vid_valid) valid_seen++;
    endtask

    task automatic idle_until(input int e);
        set_b(-3000);
        while (edge_n < e) tick();
    endtask

    task automatic fire_pulse(input string tag, output int t);
        set_b(3000);
        tick();
        exp_trig++;
        chk({tag, "_trig"}, 32'(trig), 32'd1);
        chk({tag, "_count"}, trig_count, exp_trig);
        set_b(-3000);
        t = edge_n;
    endtask

    // Expected stream: samples t+1+d+j*m for j in 0..n-1, each visible right
    // after the edge that samples it; data holds between valid samples.
    task automatic check_capture(input string tag, input int t, input int d, input int n, input int m);
        int stop;
        int off;
        int last_dat;
        stop = t + 1 + d + (n - 1) * m + 2;
        last_dat = -1;
        while (edge_n < stop) begin
            tick();
            off = edge_n - (t + 1 + d);
            if (off >= 0 && (off % m) == 0 && (off / m) < n) begin
                chk({tag, "_valid"}, 32'(vid_valid), 32'd1);
                chk({tag, "_dat"}, 32'(vid_dat), edge_n);
                chk({tag, "_first"}, 32'(vid_first), 32'(off == 0));
                chk({tag, "_last"}, 32'(vid_last), 32'(off / m == n - 1));
                last_dat = edge_n;
            end else begin
                chk({tag, "_novalid"}, 32'(vid_valid), 32'd0);
                if (last_dat >= 0) chk({tag, "_hold"}, 32'(vid_dat), last_dat);
            end
        end
    endtask

    initial begin
        int t;
        int t5;
        int e2;
        int fires;

        rst_n     = 1'b0;
        a         = DW'(1);
        b         = '0;
        enable    = 1'b0;
        excite    = DW'(2000);
        relax     = DW'(-2000);
        holdoff   = '0;
        delay     = '0;
        n_samples = '0;
        decim     = NW'(1);

        // reset state
        tick(); tick(); tick();
        chk("rst_valid", 32'(vid_valid), 32'd0);
        chk("rst_dat", 32'(vid_dat), 32'd0);
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_trig_count", trig_count, 32'd0);
        chk("rst_missed", missed_count, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_state", 32'(state), S_IDLE);
        rst_n = 1'b1;
        tick();
        chk("idle_disabled", 32'(state), S_IDLE);
        enable = 1'b1;
        tick();
        chk("idle_to_wait", 32'(state), S_WAIT);

        // ramp: one fire when B reaches 2000, no refire without a relax crossing
        e2 = -1;
        for (int v = -8000; v <= 8000; v += 1000) begin
            drive_b(v);
            if (v == 2000) e2 = edge_n;
        end
        chk("ramp_count", trig_seen, 32'd1);
        chk("ramp_edge", trig_edge, e2);
        drive_b(8000); drive_b(8000); drive_b(8000);
        drive_b(-1000); drive_b(-1000);
        drive_b(8000); drive_b(8000);
        chk("ramp_no_refire", trig_seen, 32'd1);
        chk("ramp_trig_count", trig_count, 32'd1);
        drive_b(-2000);
        drive_b(2000);
        chk("rearm_fire", trig_seen, 32'd2);
        chk("rearm_edge", trig_edge, edge_n);
        exp_trig = 2;
        chk("rearm_trig_count", trig_count, exp_trig);
        chk("n0_no_valid", valid_seen, 32'd0);
        chk("n0_state", 32'(state), S_WAIT);

        // delay 5, N 4, decim 1, trigger on sample 100
        delay = 32'd5; n_samples = 16'd4; decim = 16'd1;
        idle_until(99);
        fire_pulse("d5", t);
        chk("d5_fire_edge", t, 32'd100);
        chk("d5_state", 32'(state), S_DELAY);
        chk("d5_busy", 32'(busy), 32'd1);
        check_capture("d5", t, 5, 4, 1);

        // decim 3, N 3, delay 0
        delay = 32'd0; n_samples = 16'd3; decim = 16'd3;
        idle_until(149);
        fire_pulse("m3", t);
        chk("m3_state", 32'(state), S_CAPTURE);
        check_capture("m3", t, 0, 3, 3);

        // decim 0 behaves as 1
        delay = 32'd1; n_samples = 16'd2; decim = 16'd0;
        idle_until(179);
        fire_pulse("m0", t);
        check_capture("m0", t, 1, 2, 1);

        // holdoff 20 with B toggling every 5 samples
        holdoff = 32'd20; n_samples = 16'd0;
        idle_until(199);
        exp_q = {32'd0, 32'd21, 32'd42, 32'd63, 32'd84, 32'd110};
        fires = 0;
        t = edge_n + 1;
        for (int off = 0; off < 120; off++) begin
            set_b(((off / 5) % 2 == 0) ? 3000 : -3000);
            tick();
            if (trig) begin
                fires++;
                if (exp_q.size() == 0) chk("hold_extra_fire", off, 32'hffff_ffff);
                else chk("hold_fire_offset", edge_n - t, exp_q.pop_front());
            end
        end
        exp_trig += 6;
        chk("hold_fires", fires, 32'd6);
        chk("hold_pending", exp_q.size(), 32'd0);
        chk("hold_trig_count", trig_count, exp_trig);
        chk("hold_missed", missed_count, 32'd0);
        holdoff = 32'd0;

        // N 1000 with a second fire at j=10, config change mid-capture
        delay = 32'd0; n_samples = 16'd1000; decim = 16'd1;
        idle_until(399);
        fire_pulse("long", t5);
        for (int off = 1; off <= 1000; off++) begin
            set_b((off == 11) ? 3000 : -3000);
            if (off == 500) n_samples = 16'd2;
            tick();
            chk("long_valid", 32'(vid_valid), 32'd1);
            chk("long_dat", 32'(vid_dat), t5 + off);
            chk("long_first", 32'(vid_first), 32'(off == 1));
            chk("long_last", 32'(vid_last), 32'(off == 1000));
            if (off == 11) begin
                exp_trig++;
                chk("long_missed_trig", 32'(trig), 32'd1);
            end
        end
        chk("long_missed", missed_count, 32'd1);
        chk("long_trig_count", trig_count, exp_trig);
        chk("long_done_state", 32'(state), S_WAIT);
        fire_pulse("after_last", t);
        chk("after_last_state", 32'(state), S_CAPTURE);
        chk("after_last_missed", missed_count, 32'd1);
        check_capture("after_last", t, 0, 2, 1);

        // enable dropped at j=2 of N=8
        delay = 32'd0; n_samples = 16'd8; decim = 16'd1;
        idle_until(1449);
        fire_pulse("abort", t);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("abort_valid", 32'(vid_valid), 32'd1);
            chk("abort_dat", 32'(vid_dat), t + 1 + j);
        end
        enable = 1'b0;
        tick();
        chk("abort_state", 32'(state), S_IDLE);
        chk("abort_busy", 32'(busy), 32'd0);
        for (int j = 0; j < 7; j++) begin
            chk("abort_novalid", 32'(vid_valid), 32'd0);
            chk("abort_nolast", 32'(vid_last), 32'd0);
            tick();
        end
        enable = 1'b1;
        tick();
        chk("reenable_state", 32'(state), S_WAIT);
        delay = 32'd2; n_samples = 16'd3; decim = 16'd2;
        fire_pulse("reenable", t);
        check_capture("reenable", t, 2, 3, 2);

        // asynchronous reset in the middle of DELAY
        delay = 32'd50; n_samples = 16'd4; decim = 16'd1;
        idle_until(edge_n + 3);
        fire_pulse("arst", t);
        tick(); tick(); tick();
        chk("arst_pre_state", 32'(state), S_DELAY);
        chk("arst_pre_busy", 32'(busy), 32'd1);
        chk("arst_pre_missed", missed_count, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), S_IDLE);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_dat", 32'(vid_dat), 32'd0);
        chk("arst_valid", 32'(vid_valid), 32'd0);
        chk("arst_trig_count", trig_count, 32'd0);
        chk("arst_missed", missed_count, 32'd0);
        tick(); tick();
        chk("arst_hold_state", 32'(state), S_IDLE);
        chk("arst_hold_trig", 32'(trig), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
